// File: rtl/ysyx_22050854_pkg.sv
// Shared definitions for the ysyx_22050854 core: IFU state encoding, fault codes
// and the canonical NOP word (also used by the decoder).
package ysyx_22050854_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_BUS      = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  localparam int unsigned IFU_DATA_W = 64;

endpackage

// File: rtl/ysyx_22050854_ifu_if.sv
// Instruction-memory read bus (AR/R channels) between the IFU (master) and memory (slave).
interface ysyx_22050854_ifu_if
  import ysyx_22050854_pkg::*;
#(
  parameter int unsigned DATA_W = IFU_DATA_W
);
  logic              ar_valid;
  logic              ar_ready;
  logic [31:0]       ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output ar_valid, ar_addr, r_ready,
    input  ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready,
    output ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: one read per PC, 64->32 bit word select, holds the
// instruction for decode and discards fetches made stale by a redirect.
module ysyx_22050854_ifu
  import ysyx_22050854_pkg::*;
#(
  parameter int unsigned DATA_W   = IFU_DATA_W,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               fetch_pc,
  input  logic                      jump,
  input  logic                      id_ready,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  output logic [1:0]                inst_fault,
  output logic                      ifu_suspend,
  ysyx_22050854_ifu_if.master       bus
);

  ifu_state_e        state;
  ifu_state_e        state_next;
  logic [31:0]       req_pc;
  logic              drop;
  logic              aligned;
  logic              discard;
  logic              enter_addr;
  logic [DATA_W-1:0] beat;
  logic [31:0]       word;

  assign aligned    = (req_pc[1:0] == 2'b00);
  assign discard    = drop | jump;
  assign enter_addr = (state_next == ADDR) && (state != ADDR);
  assign beat       = bus.r_data;
  assign word       = req_pc[2] ? beat[63:32] : beat[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = ADDR;
      ADDR: begin
        if (!aligned)          state_next = HOLD;
        else if (bus.ar_ready) state_next = DATA;
      end
      DATA: begin
        if (bus.r_valid) state_next = discard ? ADDR : HOLD;
      end
      HOLD: begin
        if (jump || id_ready) state_next = ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ar_valid = (state == ADDR) && aligned;
    bus.ar_addr  = req_pc;
    bus.r_ready  = (state == DATA);
    inst_valid   = (state == HOLD);
    ifu_suspend  = ~((state == HOLD) & id_ready & ~jump);
  end

  // req_pc is re-sampled on every entry to ADDR, so a redirect seen while a
  // request is in flight only has to mark the pending beat as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc     <= '0;
      drop       <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
      inst_fault <= FAULT_NONE;
    end else begin
      if (enter_addr) begin
        req_pc <= fetch_pc;
        drop   <= 1'b0;
      end else if (jump && ((state == ADDR && aligned) || (state == DATA && !bus.r_valid))) begin
        drop <= 1'b1;
      end

      if (state == ADDR && !aligned) begin
        inst       <= NOP_INST;
        inst_pc    <= req_pc;
        inst_fault <= FAULT_MISALIGN;
      end else if (state == DATA && bus.r_valid && !discard) begin
        inst_pc <= req_pc;
        if (bus.r_resp != 2'b00) begin
          inst       <= NOP_INST;
          inst_fault <= FAULT_BUS;
        end else begin
          inst       <= word;
          inst_fault <= FAULT_NONE;
        end
      end
    end
  end

endmodule
